glitch_test_sequencer: RTL and testbench
========================================

// Module: glitch_test_sequencer
// PURPOSE
//  Self-checking stimulus sequencer for the 4-input combinational glitch circuit (inputs a,b,c,d; output x).
//  On start it walks all 16 input vectors in binary or Gray order and holds each for a settle window.
//  It then samples x and compares it against a registered 16-bit expected truth table.
//  Reports pass/fail, mismatch count and the first failing vector; sits between a test controller and the circuit.
// PARAMETERS
//  SETTLE_CYCLES  4  clock cycles each vector is held before x is sampled; legal range >= 1
// PORTS
//  clk        in   1   system clock; all state changes on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   run request; accepted only in IDLE
//  gray_mode  in   1   0: binary order 0..15; 1: Gray order idx^(idx>>1); sampled on start
//  exp_tt     in   16  expected x per vector, bit index = {a,b,c,d}; sampled on start
//  dut_x      in   1   circuit output x; synchronised externally
//  dut_in     out  4   {a,b,c,d} driven to the circuit
//  busy       out  1   high from the cycle after start acceptance until DONE completes
//  done       out  1   single-cycle pulse at end of run
//  pass       out  1   1 when err_cnt==0 at end of run; held until next accepted start
//  err_cnt    out  5   number of mismatching vectors, 0..16
//  err_vec    out  4   first mismatching vector value; 0 if none
//  glitch_cnt out  5   present only with GLITCH_COUNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, idx 0.
//  FSM: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//  IDLE:
//   - dut_in=0.
//   - On start=1: register gray_mode and exp_tt; set idx=0; drive dut_in=vec(0).
//   - Clear err_cnt, err_vec, pass (and glitch_cnt); load settle counter with SETTLE_CYCLES-1; go to SETTLE.
//  SETTLE:
//   - Hold dut_in for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
//  SAMPLE (1 cycle):
//   - Compare dut_x with exp_tt[vec(idx)].
//   - On mismatch: increment err_cnt; if err_cnt was 0, capture err_vec=vec(idx).
//   - If idx==15: go to DONE.
//   - Else: idx++, drive dut_in=vec(idx+1) on the same edge, reload settle counter, go to SETTLE.
//  DONE (1 cycle):
//   - done=1; pass=(err_cnt==0); dut_in=0; go to IDLE.
//  Latency: start sampled at edge 0; done high in cycle 1+16*(SETTLE_CYCLES+1) (81 for the default).
//  Boundary conditions:
//   - start while busy or in DONE is ignored; exp_tt/gray_mode changes mid-run have no effect.
//   - err_cnt maximum is 16, so it never wraps.
//   - idx wraps only by returning to IDLE.
//   - rst_n low mid-run aborts immediately to reset values; no done pulse.
// CONFIGURATION
//  GLITCH_COUNT_EN defined:
//   - glitch_cnt port exists.
//   - During each vector's settle window, count dut_x transitions, excluding the first settle cycle.
//   - A vector with >=2 transitions counts as one glitch; glitch_cnt increments at SAMPLE, saturating at 16.
//   - Glitches do not affect pass or err_cnt.
//  GLITCH_COUNT_EN undefined:
//   - No glitch_cnt port and no monitor logic; all other behaviour is identical.
// STRUCTURE
//  Package glitch_seq_pkg:
//   - state enum (IDLE, SETTLE, SAMPLE, DONE); NUM_VEC=16; VEC_W=4.
//   - function to_gray(idx) returning idx^(idx>>1).
//  Sub-module glitch_monitor (only under GLITCH_COUNT_EN):
//   - previous-x register, per-window transition counter, saturating glitch counter.
// TESTING
//  1. Reset: exp_tt=16'hA5C3, dut_x=exp_tt[dut_in] combinational, binary run
//     -> done at cycle 81, pass=1, err_cnt=0, err_vec=0.
//  2. Same setup, but the model inverts x for vector 9 and vector 12
//     -> pass=0, err_cnt=2, err_vec=9.
//  3. gray_mode=1
//     -> dut_in sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, each held 5 cycles; pass=1.
//  4. Assert rst_n=0 at cycle 30 of a run
//     -> all outputs 0 asynchronously, no done pulse; a new start runs a full clean pass.
//  5. Hold start=1 for the entire run
//     -> exactly one run; second run begins only after IDLE is re-entered; done pulses once per run.
//  6. GLITCH_COUNT_EN, model pulses x high for 1 cycle mid-window on vector 5 (final value correct)
//     -> glitch_cnt=1, pass=1, err_cnt=0.

Source files
------------

// File: rtl/glitch_seq_pkg.sv
// Shared types and helpers for the glitch test sequencer.
package glitch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned NUM_VEC = 16;
    localparam int unsigned VEC_W   = 4;

    // Reflected binary (Gray) code of a vector index.
    function automatic logic [VEC_W-1:0] to_gray(input logic [VEC_W-1:0] idx);
        return idx ^ (idx >> 1);
    endfunction

endpackage

// File: rtl/glitch_monitor.sv
// Per-vector glitch monitor: counts x transitions inside each settle window
// (ignoring the first settle cycle, where the vector change itself may flip x)
// and flags a vector as glitchy when it saw two or more transitions.
// Only built when GLITCH_COUNT_EN is defined.
`ifdef GLITCH_COUNT_EN
module glitch_monitor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_settle,
    input  logic       i_first,
    input  logic       i_sample,
    input  logic       i_x,
    output logic [4:0] o_glitch_cnt
);

    logic       r_prev_x;
    logic [1:0] r_trans;
    logic [4:0] r_glitch_cnt;

    // Track x from the previous cycle for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev_x <= 1'b0;
        else        r_prev_x <= i_x;
    end

    // Transition count for the current window, saturating at 2 (only >=2 matters).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trans <= '0;
        end else if (i_clear) begin
            r_trans <= '0;
        end else if (i_settle) begin
            if (i_first)
                r_trans <= '0;
            else if ((i_x != r_prev_x) && (r_trans != 2'd2))
                r_trans <= r_trans + 2'd1;
        end
    end

    // Glitchy-vector count, bumped at SAMPLE, saturating at 16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_glitch_cnt <= '0;
        else if (i_clear)
            r_glitch_cnt <= '0;
        else if (i_sample && (r_trans == 2'd2) && (r_glitch_cnt != 5'd16))
            r_glitch_cnt <= r_glitch_cnt + 5'd1;
    end

    assign o_glitch_cnt = r_glitch_cnt;

endmodule
`endif

// File: rtl/glitch_test_sequencer.sv
// Self-checking stimulus sequencer for a 4-input glitch circuit: walks all
// 16 vectors (binary or Gray order), holds each for SETTLE_CYCLES, samples x
// and compares it to a truth table captured at start.
// Optional feature macro: GLITCH_COUNT_EN adds the glitch_cnt port and monitor.
module glitch_test_sequencer
    import glitch_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             gray_mode,
    input  logic [15:0]      exp_tt,
    input  logic             dut_x,
    output logic [VEC_W-1:0] dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_cnt,
    output logic [VEC_W-1:0] err_vec
`ifdef GLITCH_COUNT_EN
    ,
    output logic [4:0]       glitch_cnt
`endif
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VEC - 1);

    state_t           r_state, w_state_nxt;
    logic [VEC_W-1:0] r_idx, w_idx_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_gray, w_gray_nxt;
    logic [15:0]      r_exp_tt, w_exp_nxt;
    logic [VEC_W-1:0] r_dut_in, w_dut_in_nxt;
    logic [4:0]       r_err_cnt, w_err_cnt_nxt;
    logic [VEC_W-1:0] r_err_vec, w_err_vec_nxt;
    logic             r_pass, w_pass_nxt;

    logic [VEC_W-1:0] w_vec_cur;
    logic [VEC_W-1:0] w_vec_nxt;
    logic             w_mismatch;

    assign w_vec_cur  = r_gray ? to_gray(r_idx) : r_idx;
    assign w_vec_nxt  = r_gray ? to_gray(r_idx + 1'b1) : (r_idx + 1'b1);
    assign w_mismatch = dut_x ^ r_exp_tt[w_vec_cur];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_gray    <= 1'b0;
            r_exp_tt  <= '0;
            r_dut_in  <= '0;
            r_err_cnt <= '0;
            r_err_vec <= '0;
            r_pass    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gray    <= w_gray_nxt;
            r_exp_tt  <= w_exp_nxt;
            r_dut_in  <= w_dut_in_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_err_vec <= w_err_vec_nxt;
            r_pass    <= w_pass_nxt;
        end
    end

    // Next-state and datapath update; vectors are registered one edge ahead.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_gray_nxt    = r_gray;
        w_exp_nxt     = r_exp_tt;
        w_dut_in_nxt  = r_dut_in;
        w_err_cnt_nxt = r_err_cnt;
        w_err_vec_nxt = r_err_vec;
        w_pass_nxt    = r_pass;
        case (r_state)
            IDLE: begin
                w_dut_in_nxt = '0;
                if (start) begin
                    w_gray_nxt    = gray_mode;
                    w_exp_nxt     = exp_tt;
                    w_idx_nxt     = '0;
                    w_dut_in_nxt  = '0;
                    w_err_cnt_nxt = '0;
                    w_err_vec_nxt = '0;
                    w_pass_nxt    = 1'b0;
                    w_cnt_nxt     = SETTLE_LOAD;
                    w_state_nxt   = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == '0) w_state_nxt = SAMPLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            SAMPLE: begin
                if (w_mismatch) begin
                    w_err_cnt_nxt = r_err_cnt + 5'd1;
                    if (r_err_cnt == '0) w_err_vec_nxt = w_vec_cur;
                end
                if (r_idx == LAST_IDX) begin
                    // pass is decided here so it is already valid while done is high
                    w_pass_nxt   = (r_err_cnt == '0) && !w_mismatch;
                    w_dut_in_nxt = '0;
                    w_state_nxt  = DONE;
                end else begin
                    w_idx_nxt    = r_idx + 1'b1;
                    w_dut_in_nxt = w_vec_nxt;
                    w_cnt_nxt    = SETTLE_LOAD;
                    w_state_nxt  = SETTLE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign dut_in  = r_dut_in;
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);
    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;
    assign err_vec = r_err_vec;

`ifdef GLITCH_COUNT_EN
    logic w_start_acc;
    logic w_first_settle;

    assign w_start_acc    = (r_state == IDLE) && start;
    assign w_first_settle = (r_state == SETTLE) && (r_cnt == SETTLE_LOAD);

    glitch_monitor u_glitch_monitor (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_start_acc),
        .i_settle     (r_state == SETTLE),
        .i_first      (w_first_settle),
        .i_sample     (r_state == SAMPLE),
        .i_x          (dut_x),
        .o_glitch_cnt (glitch_cnt)
    );
`else
    // No glitch monitor in this build.
`endif

endmodule

// File: tb/tb_glitch_test_sequencer.sv
// Testbench for glitch_test_sequencer: directed scenarios plus randomized runs,
// checked against a run-level reference model (expected vector order, error
// count, first failing vector, done timing).
module tb_glitch_test_sequencer;

    localparam int S = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        gray_mode;
    logic [15:0] exp_tt;
    logic        dut_x;
    logic [3:0]  dut_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_cnt;
    logic [3:0]  err_vec;
`ifdef GLITCH_COUNT_EN
    logic [4:0]  glitch_cnt;
`endif

    logic [15:0] circuit_tt;
    logic        pulse;
    logic [3:0]  gray_seq [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                   4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    int n_checks = 0;
    int n_errors = 0;

    glitch_test_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .gray_mode  (gray_mode),
        .exp_tt     (exp_tt),
        .dut_x      (dut_x),
        .dut_in     (dut_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
`ifdef GLITCH_COUNT_EN
        .err_vec    (err_vec),
        .glitch_cnt (glitch_cnt)
`else
        .err_vec    (err_vec)
`endif
    );

    // Circuit under test: faulty truth table plus an optional injected pulse.
    assign dut_x = circuit_tt[dut_in] ^ pulse;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One run, started from a negedge. abort_at>0 pulls reset in that cycle.
    task automatic run(input logic [15:0] tt, input logic g, input logic [15:0] mask,
                       input int pulse_vec, input bit keep, input int abort_at);
        logic [3:0] ord [16];
        logic [3:0] exp_vec;
        bit         found;
        int         exp_err, exp_glitch, last, v, p, part_err;
        last = 16 * (S + 1) + 1;
        for (int i = 0; i < 16; i++) ord[i] = g ? gray_seq[i] : 4'(i);
        exp_err = $countones(mask);
        found   = 0;
        exp_vec = 4'd0;
        for (int i = 0; i < 16; i++)
            if (!found && mask[ord[i]]) begin
                exp_vec = ord[i];
                found   = 1;
            end
        exp_glitch = (pulse_vec >= 0 && S >= 3) ? 1 : 0;
        circuit_tt = tt ^ mask;
        start      = 1'b1;
        exp_tt     = tt;
        gray_mode  = g;
        pulse      = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                part_err = 0;
                for (int i = 0; i < (k - 1) / (S + 1); i++) part_err += int'(mask[ord[i]]);
                check("pre_rst_err_cnt", 32'(err_cnt), 32'(part_err));
                #2 rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_dut_in", 32'(dut_in), 32'd0);
                check("rst_err_cnt", 32'(err_cnt), 32'd0);
                check("rst_err_vec", 32'(err_vec), 32'd0);
                check("rst_pass", 32'(pass), 32'd0);
`ifdef GLITCH_COUNT_EN
                check("rst_glitch", 32'(glitch_cnt), 32'd0);
`endif
                start = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("rst_hold_done", 32'(done), 32'd0);
                    check("rst_hold_busy", 32'(busy), 32'd0);
                end
                rst_n = 1'b1;
                return;
            end
            if (k < last) check("dut_in", 32'(dut_in), 32'(ord[(k - 1) / (S + 1)]));
            else          check("dut_in_done", 32'(dut_in), 32'd0);
            check("busy", 32'(busy), 32'd1);
            check("done", 32'(done), 32'(k == last));
            if (k == last) begin
                check("pass", 32'(pass), 32'(exp_err == 0));
                check("err_cnt", 32'(err_cnt), 32'(exp_err));
                check("err_vec", 32'(err_vec), 32'(exp_vec));
`ifdef GLITCH_COUNT_EN
                check("glitch_cnt", 32'(glitch_cnt), 32'(exp_glitch));
`endif
            end
            if (!keep) start = 1'($urandom);
            exp_tt    = 16'($urandom);
            gray_mode = 1'($urandom);
            pulse     = 1'b0;
            if (k < last && pulse_vec >= 0) begin
                v = (k - 1) / (S + 1);
                p = (k - 1) % (S + 1);
                if (int'(ord[v]) == pulse_vec && p == 1) pulse = 1'b1;
            end
        end
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_dut_in", 32'(dut_in), 32'd0);
        check("held_pass", 32'(pass), 32'(exp_err == 0));
        check("held_err_cnt", 32'(err_cnt), 32'(exp_err));
        if (!keep) start = 1'b0;
    endtask

    initial begin
        logic [15:0] rtt, rmask;
        int          pv;
        bit          kp;
        rst_n      = 1'b0;
        start      = 1'b0;
        gray_mode  = 1'b0;
        exp_tt     = '0;
        circuit_tt = '0;
        pulse      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        check("reset_err_vec", 32'(err_vec), 32'd0);
        check("reset_dut_in", 32'(dut_in), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(16'hA5C3, 1'b0, 16'h0000, -1, 1'b0, 0);
        run(16'hA5C3, 1'b0, 16'h1200, -1, 1'b0, 0);
        run(16'hA5C3, 1'b1, 16'h0000, -1, 1'b0, 0);
        run(16'hA5C3, 1'b0, 16'h000A, -1, 1'b0, 30);
        run(16'hA5C3, 1'b0, 16'h0000, -1, 1'b0, 0);
        run(16'hA5C3, 1'b0, 16'h0000, -1, 1'b1, 0);
        run(16'hA5C3, 1'b0, 16'h0000, -1, 1'b0, 0);
        run(16'hA5C3, 1'b0, 16'h0000, 5, 1'b0, 0);
        run(16'h3C5A, 1'b1, 16'h0900, 9, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            rtt   = 16'($urandom);
            rmask = 16'($urandom & $urandom & $urandom);
            pv    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
            kp    = (i < 7) ? 1'($urandom) : 1'b0;
            run(rtt, 1'($urandom), rmask, pv, kp, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
